// File: rtl/alu_adder_post.sv
// Post-adder stage of the 6502 ALU: registers the binary sum, applies the BCD adjust
// for decimal ADC/SBC, and produces N/Z/C/V through a start/valid/ack handshake.
module alu_adder_post #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          DEC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             c6out,
  input  logic             decimal,
  input  logic             sub,
  input  logic             ack,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             valid,
  output logic             busy
);

  localparam int unsigned NIB = 4;

  typedef enum logic [1:0] {IDLE, ADJ, DONE} state_t;

  state_t           state, state_next;
  logic             take;
  logic             dec_in, hc_in, v_in;
  logic [WIDTH-1:0] h_sum;
  logic             h_cout, h_hc, h_v, h_sub, h_dec;
  logic [WIDTH-1:0] adj_result;
  logic             adj_c;

  // Carry into bit 4 recovered from the parity of operands and sum at that bit.
  assign hc_in  = ^((op_a ^ op_b ^ sum) & WIDTH'(8'h10));
  assign v_in   = c6out ^ cout;
  assign dec_in = decimal & DEC_EN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A back-to-back op from DONE always passes through ADJ so valid drops for a cycle.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      IDLE: if (start) begin
        take       = 1'b1;
        state_next = dec_in ? ADJ : DONE;
      end
      ADJ:  state_next = DONE;
      DONE: if (ack) begin
        if (start) begin
          take       = 1'b1;
          state_next = ADJ;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_sum  <= '0;
      h_cout <= 1'b0;
      h_hc   <= 1'b0;
      h_v    <= 1'b0;
      h_sub  <= 1'b0;
      h_dec  <= 1'b0;
    end else if (take) begin
      h_sum  <= sum;
      h_cout <= cout;
      h_hc   <= hc_in;
      h_v    <= v_in;
      h_sub  <= sub;
      h_dec  <= dec_in;
    end
  end

  // Decimal adjust; the nibble corrections wrap modulo 256.
  always_comb begin
    adj_result = h_sum;
    adj_c      = h_cout;
    if (h_dec && !h_sub) begin
      if ((h_sum[NIB-1:0] > 4'd9) || h_hc) adj_result = adj_result + WIDTH'(8'h06);
      if ((adj_result[WIDTH-1:NIB] > 4'd9) || h_cout) begin
        adj_result = adj_result + WIDTH'(8'h60);
        adj_c      = 1'b1;
      end
    end else if (h_dec && h_sub) begin
      if (!h_hc)   adj_result = adj_result - WIDTH'(8'h06);
      if (!h_cout) adj_result = adj_result - WIDTH'(8'h60);
    end
  end

  // N and Z are loaded alongside result so they follow it yet clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= (state_next == DONE);
      busy  <= (state_next != IDLE);
      if (take && (state_next == DONE)) begin
        result <= sum;
        flag_n <= sum[WIDTH-1];
        flag_z <= (sum == '0);
        flag_c <= cout;
        flag_v <= v_in;
      end else if (state == ADJ) begin
        result <= adj_result;
        flag_n <= adj_result[WIDTH-1];
        flag_z <= (adj_result == '0);
        flag_c <= adj_c;
        flag_v <= h_v;
      end
    end
  end

endmodule
